// File: rtl/rvv_xrf_wb_collector.sv
`default_nettype none
// ============================================================================
// Module   : rvv_xrf_wb_collector
// Brief    : Collects up to NUM_RT_UOP scalar write-backs per cycle into a
//            circular queue and drains them one per cycle onto async_rd.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_xrf_wb_collector #(
    parameter int NUM_RT_UOP = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_RT_UOP-1:0]          rt_xrf_valid_i,
    input  logic [NUM_RT_UOP*ADDR_W-1:0]   rt_xrf_index_i,
    input  logic [NUM_RT_UOP*DATA_W-1:0]   rt_xrf_data_i,
    output logic [NUM_RT_UOP-1:0]          rt_xrf_ready_o,
    output logic                           async_rd_valid_o,
    output logic [ADDR_W-1:0]              async_rd_addr_o,
    output logic [DATA_W-1:0]              async_rd_data_o,
    input  logic                           async_rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]     fill_level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]     r_mem_addr [DEPTH];
    logic [DATA_W-1:0]     r_mem_data [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [CNT_W-1:0]      w_space;
    logic [NUM_RT_UOP-1:0] w_ready;
    logic [NUM_RT_UOP-1:0] w_acc;
    logic [CNT_W-1:0]      w_n_acc;
    logic [PTR_W-1:0]      w_waddr [NUM_RT_UOP];
    logic                  w_pop;

    // Readiness looks only at the registered count, so a pop this cycle
    // cannot open a slot until the following cycle.
    always_comb begin
        w_space = CNT_W'(DEPTH) - r_count;
        w_ready = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            w_ready[i] = (i < int'(w_space));
        end
    end

    assign w_acc = rt_xrf_valid_i & w_ready;

    // Each accepted slot lands after all lower accepted slots of the same cycle.
    always_comb begin
        w_n_acc = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            w_waddr[i] = r_wr_ptr + w_n_acc[PTR_W-1:0];
            if (w_acc[i]) begin
                w_n_acc = w_n_acc + CNT_W'(1);
            end
        end
    end

    assign w_pop = (r_count != '0) && async_rd_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_mem_addr[e] <= '0;
                r_mem_data[e] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                if (w_acc[i]) begin
                    r_mem_addr[w_waddr[i]] <= rt_xrf_index_i[i*ADDR_W +: ADDR_W];
                    r_mem_data[w_waddr[i]] <= rt_xrf_data_i[i*DATA_W +: DATA_W];
                end
            end
            r_wr_ptr <= r_wr_ptr + w_n_acc[PTR_W-1:0];
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_n_acc - CNT_W'(w_pop);
        end
    end

    assign rt_xrf_ready_o   = w_ready & {NUM_RT_UOP{rstn}};
    assign async_rd_valid_o = (r_count != '0);
    assign async_rd_addr_o  = r_mem_addr[r_rd_ptr];
    assign async_rd_data_o  = r_mem_data[r_rd_ptr];
    assign fill_level_o     = r_count;

    a_valid_prefix : assert property (@(posedge clk) disable iff (!rstn)
        ((rt_xrf_valid_i >> 1) & ~rt_xrf_valid_i) == '0);

    a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
        int'(r_count) <= DEPTH);

    a_push_ready : assert property (@(posedge clk) disable iff (!rstn)
        (w_acc & ~rt_xrf_ready_o) == '0);

    a_hold_stable : assert property (@(posedge clk) disable iff (!rstn)
        (async_rd_valid_o && !async_rd_ready_i) |=>
        (async_rd_valid_o && $stable(async_rd_addr_o) && $stable(async_rd_data_o)));

endmodule
`default_nettype wire
